key_event_queue: RTL

Turns the 40-bit live keyboard state from the key/display I/O block into a debounced, ordered queue of key-press/release events for the DPC control core. Sits directly downstream of the keyboard scanner. Each 1 ms tick it samples `keysCurrentState` and debounces the whole vector. It serially scans the changed keys and pushes one coded event per change into a small FIFO. The core drains the FIFO with a valid/ready handshake.

---
 rtl/key_event_pkg.sv | 22 ++
 rtl/key_event_fifo.sv | 82 ++++++++
 rtl/key_event_queue.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg: shared types for the keyboard event queue.
// Holds the event record, key-code width and scanner state encoding.
package key_event_pkg;

  localparam int KEY_CODE_WIDTH = 6;

  // Width of the debounce counter; DEBOUNCE_TICKS is limited to 1..15.
  localparam int STABLE_CNT_WIDTH = 4;

  // One queued key event. The flag cannot be called "release" because
  // that word is reserved in SystemVerilog.
  typedef struct packed {
    logic                      release_flag;
    logic [KEY_CODE_WIDTH-1:0] code;
  } key_event_t;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: synchronous show-ahead FIFO for packed key events.
// The head entry is visible combinationally; drop/overflow policy lives in
// the parent. Occupancy is tracked by an explicit counter, not pointer math.
module key_event_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 7,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A pop from an empty FIFO is ignored; a push into a full FIFO only
  // succeeds if a pop frees the head slot in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Next pointers and occupancy; clear wins over any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) begin
        count_d = count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates the head.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Head is forced to zero while empty so stale or uninitialised entries
  // never appear on the outputs.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: debounces the live keyboard vector on 1 ms ticks, scans
// accepted changes in ascending key order and queues one event per change.
// Build option: define KEY_EVENT_RELEASE_EN to queue release events too;
// otherwise only presses are queued and evt_release is held at 0.
module key_event_queue
  import key_event_pkg::*;
#(
  parameter int KEYS           = 40,
  parameter int DEPTH          = 8,
  parameter int DEBOUNCE_TICKS = 4,
  localparam int CNT_W         = $clog2(DEPTH) + 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Tick_1ms,
  input  logic [KEYS-1:0]           keysCurrentState,
  input  logic                      clear,
  output logic                      evt_valid,
  output logic [KEY_CODE_WIDTH-1:0] evt_code,
  output logic                      evt_release,
  input  logic                      evt_ready,
  output logic [CNT_W-1:0]          count,
  output logic                      overflow,
  output logic                      busy
);

`ifdef KEY_EVENT_RELEASE_EN
  localparam int EVT_W = KEY_CODE_WIDTH + 1;
`else
  localparam int EVT_W = KEY_CODE_WIDTH;
`endif

  localparam logic [STABLE_CNT_WIDTH-1:0] STABLE_MAX = STABLE_CNT_WIDTH'(DEBOUNCE_TICKS);
  localparam logic [KEY_CODE_WIDTH-1:0]   LAST_IDX   = KEY_CODE_WIDTH'(KEYS - 1);

  // Debounce state.
  logic [KEYS-1:0]             sample_q, sample_d;
  logic [STABLE_CNT_WIDTH-1:0] stable_cnt_q, stable_cnt_d;

  // Scanner state.
  scan_state_e                 state_q, state_d;
  logic [KEYS-1:0]             debounced_q, debounced_d;
  logic [KEYS-1:0]             diff_q, diff_d;
  logic [KEY_CODE_WIDTH-1:0]   idx_q, idx_d;
  logic                        overflow_q, overflow_d;

  // Scanner-to-FIFO and FIFO-to-output wiring.
  logic                        push_req;
  logic [EVT_W-1:0]            push_data;
  logic                        pop_req;
  logic [EVT_W-1:0]            head_data;
  logic [CNT_W-1:0]            fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  key_event_t                  head_evt;

  // Debounce: a new vector restarts the stability count, a repeat extends it.
  always_comb begin
    sample_d     = sample_q;
    stable_cnt_d = stable_cnt_q;
    if (Tick_1ms) begin
      if (keysCurrentState != sample_q) begin
        sample_d     = keysCurrentState;
        stable_cnt_d = '0;
      end else if (stable_cnt_q != STABLE_MAX) begin
        stable_cnt_d = stable_cnt_q + 1'b1;
      end
    end
  end

  // Scanner next-state and push generation. The start test looks at the
  // counter's next value so a scan begins on the edge of the qualifying tick;
  // sample never changes on that edge, so sample_q is the settled vector.
  always_comb begin
    state_d     = state_q;
    debounced_d = debounced_q;
    diff_d      = diff_q;
    idx_d       = idx_q;
    push_req    = 1'b0;
    push_data   = '0;
    case (state_q)
      SCAN_IDLE: begin
        if ((stable_cnt_d == STABLE_MAX) && (sample_q != debounced_q)) begin
          state_d     = SCAN_RUN;
          diff_d      = sample_q ^ debounced_q;
          debounced_d = sample_q;
          idx_d       = '0;
        end
      end
      SCAN_RUN: begin
`ifdef KEY_EVENT_RELEASE_EN
        push_req  = diff_q[idx_q];
        push_data = {~debounced_q[idx_q], idx_q};
`else
        // Released keys are skipped: only a changed bit that is now pressed.
        push_req  = diff_q[idx_q] & debounced_q[idx_q];
        push_data = idx_q;
`endif
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = SCAN_IDLE;
        end
      end
      default: state_d = SCAN_IDLE;
    endcase
  end

  // Sticky overflow: set when a push finds the FIFO full with no pop to
  // make room; cleared only by clear or reset.
  always_comb begin
    overflow_d = overflow_q;
    if (clear) begin
      overflow_d = 1'b0;
    end else if (push_req && fifo_full && !pop_req) begin
      overflow_d = 1'b1;
    end
  end

  // State registers for debounce, scanner and overflow flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sample_q     <= '0;
      stable_cnt_q <= '0;
      state_q      <= SCAN_IDLE;
      debounced_q  <= '0;
      diff_q       <= '0;
      idx_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      sample_q     <= sample_d;
      stable_cnt_q <= stable_cnt_d;
      state_q      <= state_d;
      debounced_q  <= debounced_d;
      diff_q       <= diff_d;
      idx_q        <= idx_d;
      overflow_q   <= overflow_d;
    end
  end

  assign pop_req = evt_valid & evt_ready;

  key_event_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (EVT_W)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Rst),
    .clear     (clear),
    .push      (push_req),
    .push_data (push_data),
    .pop       (pop_req),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Unpack the FIFO head into the event record.
  always_comb begin
    head_evt      = '0;
    head_evt.code = head_data[KEY_CODE_WIDTH-1:0];
`ifdef KEY_EVENT_RELEASE_EN
    head_evt.release_flag = head_data[EVT_W-1];
`endif
  end

  assign evt_valid   = ~fifo_empty;
  assign evt_code    = head_evt.code;
  assign evt_release = head_evt.release_flag;
  assign count       = fifo_count;
  assign overflow    = overflow_q;
  assign busy        = (state_q == SCAN_RUN);

endmodule
